tc11_mod_accumulator: RTL

Sequential modulo-11 accumulator for the RNS datapath. It operates entirely in 10-bit thermometer code: it accepts a packet of thermometer-coded mod-11 residues over a valid/ready stream and sums them modulo 11. Each packet produces one thermometer-coded result, which the block presents downstream to the mod-11 thermometer-to-binary converter. A result is held under backpressure until the consumer takes it.

---
 rtl/tc11_pkg.sv | 20 ++
 rtl/tc11_mod_add.sv | 10 +
 rtl/tc11_mod_accumulator.sv | 67 ++++++
 3 files changed

// File: rtl/tc11_pkg.sv
// tc11_pkg: shared mod-11 thermometer-code constants, FSM states and helpers
package tc11_pkg;
  localparam int TC11_W = 10;
  localparam int TC11_MOD = 11;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  // a thermometer code has no 0 below a 1, so adding 1 clears every set bit
  function automatic logic tc11_is_legal(input logic [TC11_W-1:0] tc);
    logic [TC11_W:0] e;
    e = {1'b0, tc};
    return (e & (e + 1'b1)) == '0;
  endfunction
  function automatic logic [TC11_W-1:0] tc11_add(input logic [TC11_W-1:0] a, input logic [TC11_W-1:0] b);
    logic [4:0] s;
    logic [TC11_W:0] t;
    s = 5'($countones(a)) + 5'($countones(b));
    s = (s >= 5'(TC11_MOD)) ? s - 5'(TC11_MOD) : s;
    t = (11'd1 << s) - 11'd1;
    return t[TC11_W-1:0];
  endfunction
endpackage

// File: rtl/tc11_mod_add.sv
// tc11_mod_add: combinational mod-11 thermometer adder; a, b legal codes in, s = (a+b) mod 11 out
module tc11_mod_add
  import tc11_pkg::*;
(
  input  logic [TC11_W-1:0] a,
  input  logic [TC11_W-1:0] b,
  output logic [TC11_W-1:0] s
);
  assign s = tc11_add(a, b);
endmodule

// File: rtl/tc11_mod_accumulator.sv
// tc11_mod_accumulator: packet-wise mod-11 thermometer accumulator; in_* operand stream, out_* result stream with sum, count and error flag
module tc11_mod_accumulator
  import tc11_pkg::*;
#(
  parameter int MAX_OPS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TC11_W-1:0] in_tc,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TC11_W-1:0] out_tc,
  output logic [3:0]        out_count,
  output logic              out_err
);
  state_t state, state_n;
  logic [TC11_W-1:0] acc, acc_n, acc_base, op, sum;
  logic [3:0] cnt, cnt_n, cnt_base, cnt_inc;
  logic err, err_n, legal, accept, term;
  assign out_valid = state == DONE;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign legal = tc11_is_legal(in_tc);
  assign op = legal ? in_tc : '0;
  // any beat accepted outside ACCUM opens a fresh packet
  assign acc_base = state == ACCUM ? acc : '0;
  assign cnt_base = state == ACCUM ? cnt : '0;
  assign cnt_inc = cnt_base + 4'd1;
  assign term = in_last || cnt_inc == 4'(MAX_OPS);
  tc11_mod_add u_add (.a(acc_base), .b(op), .s(sum));
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    err_n = err;
    if (accept) begin
      state_n = term ? DONE : ACCUM;
      acc_n = sum;
      cnt_n = cnt_inc;
      err_n = (state == ACCUM && err) || !legal;
    end else if (out_valid && out_ready) begin
      state_n = IDLE;
      acc_n = '0;
      cnt_n = '0;
      err_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      err <= err_n;
    end
  end
  assign out_tc = acc;
  assign out_count = cnt;
  assign out_err = err;
endmodule
